fft_ctrl_param: RTL and testbench
=================================

# fft_ctrl_param

Parametrised address/control generator for an in-place radix-2 DIF FFT built on two dual-port SRAM banks of N/2 words. Sequences one frame: load N samples, run LOG2N butterfly stages with conflict-free bank mapping and a programmable butterfly latency, then unload N results. It drives the SRAM ports, input/output swap muxes and twiddle ROM index. It sits between the sample interface and the butterfly/memory datapath.

## Interface
- LOG2N, 6, log2 of FFT size N (3..10); bank depth N/2, address width AW = LOG2N-1
- BF_LAT, 2, cycles from SRAM read to butterfly result write (>= 2)
- clk  in  1  clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  frame request, sampled in IDLE
- valid  in  1  global advance enable; all state, counters and pipelines hold when 0
- busy  out  1  high from LOAD through end of UNLOAD
- in_ready  out  1  high in LOAD; sample on data bus is written this cycle
- stage  out  4  0 = load/idle, 1..LOG2N = butterfly stage, LOG2N+1 = unload
- we_b0, we_b1, re_b0, re_b1  out  1 each  bank write/read enables
- waddr_b0, waddr_b1, raddr_b0, raddr_b1  out  AW each  bank addresses
- swap0_en  out  1  read-side pair swap, aligned with SRAM read data
- swap1_en  out  1  write-side pair swap, aligned with write cycle
- tw_idx  out  AW  twiddle index, aligned with swap0_en
- bank_select  out  1  write bank in LOAD; output-mux select in UNLOAD (aligned with out_valid)
- out_valid  out  1  result sample present on SRAM read data
- frame_done  out  1  one-cycle pulse with final out_valid

## Operation
- Mapping: element index i lives in bank p(i) = XOR of all bits of i, address i>>1. Butterfly pairs always differ in parity, so both banks are accessed every stage cycle.
- FSM IDLE -> LOAD -> STAGE(1..LOG2N) -> UNLOAD -> IDLE. IDLE -> LOAD on start=1 and valid=1; start ignored while busy.
- LOAD: k = 0..N-1; we_b{p(k)}=1, other we=0; both waddr = k>>1; bank_select = p(k); re=0.
- STAGE s, span h = 2^(LOG2N-s): N/2 read cycles m, then BF_LAT drain cycles with re=0. j = m with a 0 inserted at bit LOG2N-s; partner k = j|h. If p(j)=0: raddr_b0=j>>1, raddr_b1=k>>1, swap=0; else addresses exchanged, swap=1. re_b0=re_b1=1.
- tw_idx = (m mod h) << (s-1) (0 in final stage).
- Writes: exactly BF_LAT valid cycles after each read, we_b0=we_b1=1 with that read's addresses (in-place); swap1_en = swap delayed BF_LAT; swap0_en = swap delayed 1.
- UNLOAD: k = 0..N-1, idx as per Configuration; re_b{p(idx)}=1, raddr = idx>>1, we=0. out_valid and bank_select=p(idx) follow 1 valid cycle later.
- Outputs not listed for a state are 0.

## Timing
- Reset: state IDLE, all counters/pipelines cleared, every output 0. Reset mid-frame aborts immediately; no write occurs after nrst falls.
- valid=0: all we/re forced 0, nothing advances; resumes exactly where held.
- Frame length in valid cycles, start accept to frame_done: N + LOG2N*(N/2+BF_LAT) + N + 1; N=64, BF_LAT=2: 333.
- Stage-to-stage: first read of stage s+1 follows last write of stage s by 1 cycle; no read-after-write hazard.
- SRAM read latency fixed at 1 cycle.

## Configuration
- FFTC_NATURAL_ORDER_EN defined: UNLOAD idx = bit-reverse(k) over LOG2N bits, results in natural order.
- Not defined: idx = k, results in bit-reversed order; bit-reversal logic absent.

## Test plan
- Reset: assert nrst=0 mid-STAGE 3 -> all outputs 0 same cycle; start after release -> LOAD begins, in_ready=1.
- LOAD, LOG2N=6: k=3 -> we_b0=1, waddr=1, bank_select=0; k=7 -> we_b1=1, waddr=3.
- STAGE 1, LOG2N=6: m=0 -> raddr_b0=0, raddr_b1=16, swap0_en=0 next cycle; m=1 -> raddr_b0=16, raddr_b1=0, swap0_en=1, tw_idx=1; writes with same addresses 2 cycles later.
- STAGE 6: m=3 -> raddr_b0=3, raddr_b1=3, tw_idx=0; drain 2 cycles then UNLOAD.
- UNLOAD with FFTC_NATURAL_ORDER_EN: k=1 -> re_b1=1, raddr_b1=16; next cycle out_valid=1, bank_select=1; frame_done at valid cycle 333.
- valid toggled 1/0 randomly across whole frame, LOG2N=4, BF_LAT=3 -> address/enable sequence identical to unstalled run; frame_done after 16+4*11+16+1=77 valid cycles.

Source files
------------

// File: rtl/fft_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : fft_ctrl_param
// Purpose  : Address/control sequencer for an in-place radix-2 DIF FFT on two
//            parity-mapped SRAM banks. Macro FFTC_NATURAL_ORDER_EN selects
//            natural-order unload (bit-reversed read index).
// Revision : 1.0
// ============================================================================
module fft_ctrl_param #(
    parameter int LOG2N  = 6,
    parameter int BF_LAT = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             valid,
    output logic             busy,
    output logic             in_ready,
    output logic [3:0]       stage,
    output logic             we_b0,
    output logic             we_b1,
    output logic             re_b0,
    output logic             re_b1,
    output logic [LOG2N-2:0] waddr_b0,
    output logic [LOG2N-2:0] waddr_b1,
    output logic [LOG2N-2:0] raddr_b0,
    output logic [LOG2N-2:0] raddr_b1,
    output logic             swap0_en,
    output logic             swap1_en,
    output logic [LOG2N-2:0] tw_idx,
    output logic             bank_select,
    output logic             out_valid,
    output logic             frame_done
);

    localparam int N    = 1 << LOG2N;
    localparam int AW   = LOG2N - 1;
    localparam int HALF = N / 2;
    localparam int CW   = $clog2(N + BF_LAT) + 1;

    localparam logic [CW-1:0] C_LOAD_LAST = CW'(N - 1);
    localparam logic [CW-1:0] C_STG_LAST  = CW'(HALF + BF_LAT - 1);
    localparam logic [CW-1:0] C_UNL_LAST  = CW'(N);
    localparam logic [CW-1:0] C_HALF      = CW'(HALF);
    localparam logic [3:0]    C_LOG2N     = 4'(LOG2N);
    localparam logic [3:0]    C_UNL_STAGE = 4'(LOG2N + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_STAGE  = 2'd2,
        S_UNLOAD = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    stg_q, stg_d;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            stg_q   <= '0;
        end else if (valid) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == C_LOAD_LAST) begin
                    state_d = S_STAGE;
                    cnt_d   = '0;
                    stg_d   = 4'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STAGE: begin
                if (cnt_q == C_STG_LAST) begin
                    cnt_d = '0;
                    if (stg_q == C_LOG2N) begin
                        state_d = S_UNLOAD;
                        stg_d   = '0;
                    end else begin
                        stg_d = stg_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_UNLOAD: begin
                if (cnt_q == C_UNL_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- butterfly pair addressing ----------------
    // j = m with a zero inserted at bit (LOG2N-s); partner k = j | span.
    logic [3:0]       w_shamt;
    logic [LOG2N-1:0] w_span, w_lowmask, w_mx, w_j, w_k_ld, w_uidx;
    logic [AW-1:0]    w_khi, w_ra0, w_ra1, w_tw;
    logic             w_swap, w_rd, w_urd, w_upar, w_lpar;

    assign w_shamt   = C_LOG2N - stg_q;
    assign w_span    = LOG2N'(1) << w_shamt;
    assign w_lowmask = w_span - LOG2N'(1);
    assign w_mx      = {1'b0, cnt_q[AW-1:0]};
    assign w_j       = ((w_mx & ~w_lowmask) << 1) | (w_mx & w_lowmask);
    assign w_khi     = AW'((w_j | w_span) >> 1);
    assign w_swap    = ^w_j;
    assign w_ra0     = w_swap ? w_khi : w_j[LOG2N-1:1];
    assign w_ra1     = w_swap ? w_j[LOG2N-1:1] : w_khi;
    assign w_tw      = AW'((w_mx & w_lowmask) << (stg_q - 4'd1));
    assign w_rd      = (state_q == S_STAGE) && (cnt_q < C_HALF);

    assign w_k_ld    = cnt_q[LOG2N-1:0];
    assign w_lpar    = ^w_k_ld;
    assign w_urd     = (state_q == S_UNLOAD) && (cnt_q != C_UNL_LAST);
    assign w_upar    = ^w_uidx;

`ifdef FFTC_NATURAL_ORDER_EN
    for (genvar gi = 0; gi < LOG2N; gi++) begin : g_bitrev
        assign w_uidx[gi] = w_k_ld[LOG2N-1-gi];
    end
`else
    assign w_uidx = w_k_ld;
`endif

    // ---------------- read-to-write and unload pipelines ----------------
    logic          pv_q  [BF_LAT];
    logic          ps_q  [BF_LAT];
    logic [AW-1:0] pa0_q [BF_LAT];
    logic [AW-1:0] pa1_q [BF_LAT];
    logic [AW-1:0] tw1_q;
    logic          ov_q, ob_q, ol_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < BF_LAT; i++) begin
                pv_q[i]  <= 1'b0;
                ps_q[i]  <= 1'b0;
                pa0_q[i] <= '0;
                pa1_q[i] <= '0;
            end
            tw1_q <= '0;
            ov_q  <= 1'b0;
            ob_q  <= 1'b0;
            ol_q  <= 1'b0;
        end else if (valid) begin
            pv_q[0]  <= w_rd;
            ps_q[0]  <= w_swap;
            pa0_q[0] <= w_ra0;
            pa1_q[0] <= w_ra1;
            for (int i = 1; i < BF_LAT; i++) begin
                pv_q[i]  <= pv_q[i-1];
                ps_q[i]  <= ps_q[i-1];
                pa0_q[i] <= pa0_q[i-1];
                pa1_q[i] <= pa1_q[i-1];
            end
            tw1_q <= w_tw;
            ov_q  <= w_urd;
            ob_q  <= w_upar;
            ol_q  <= w_urd && (cnt_q == C_LOAD_LAST);
        end
    end

    // ---------------- outputs (all strobes/addresses gated by valid) ----------------
    always_comb begin
        busy        = (state_q != S_IDLE);
        stage       = 4'd0;
        in_ready    = 1'b0;
        we_b0       = 1'b0;
        we_b1       = 1'b0;
        re_b0       = 1'b0;
        re_b1       = 1'b0;
        waddr_b0    = '0;
        waddr_b1    = '0;
        raddr_b0    = '0;
        raddr_b1    = '0;
        swap0_en    = 1'b0;
        swap1_en    = 1'b0;
        tw_idx      = '0;
        bank_select = 1'b0;
        out_valid   = 1'b0;
        frame_done  = 1'b0;

        if (state_q == S_STAGE) begin
            stage = stg_q;
        end else if (state_q == S_UNLOAD) begin
            stage = C_UNL_STAGE;
        end

        if (valid) begin
            case (state_q)
                S_LOAD: begin
                    in_ready    = 1'b1;
                    we_b0       = ~w_lpar;
                    we_b1       = w_lpar;
                    waddr_b0    = w_k_ld[LOG2N-1:1];
                    waddr_b1    = w_k_ld[LOG2N-1:1];
                    bank_select = w_lpar;
                end
                S_STAGE: begin
                    if (w_rd) begin
                        re_b0    = 1'b1;
                        re_b1    = 1'b1;
                        raddr_b0 = w_ra0;
                        raddr_b1 = w_ra1;
                    end
                end
                S_UNLOAD: begin
                    if (w_urd) begin
                        re_b0    = ~w_upar;
                        re_b1    = w_upar;
                        raddr_b0 = w_uidx[LOG2N-1:1];
                        raddr_b1 = w_uidx[LOG2N-1:1];
                    end
                end
                default: ;
            endcase

            if (pv_q[BF_LAT-1]) begin
                we_b0    = 1'b1;
                we_b1    = 1'b1;
                waddr_b0 = pa0_q[BF_LAT-1];
                waddr_b1 = pa1_q[BF_LAT-1];
                swap1_en = ps_q[BF_LAT-1];
            end
            if (pv_q[0]) begin
                swap0_en = ps_q[0];
                tw_idx   = tw1_q;
            end
            if (ov_q) begin
                out_valid   = 1'b1;
                bank_select = ob_q;
                frame_done  = ol_q;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fft_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_ctrl_param
// Purpose  : Directed vector table for LOG2N=6/BF_LAT=2 plus reset-abort and
//            randomly stalled frame on a LOG2N=4/BF_LAT=3 instance.
// Revision : 1.0
// ============================================================================
module tb_fft_ctrl_param;

    typedef struct packed {
        logic [3:0] stage;
        logic       busy, in_ready, we0, we1, re0, re1, sw0, sw1, bs, ov, fd;
        logic [9:0] wa0, wa1, ra0, ra1, tw;
    } obs_t;

    typedef struct {
        int   t;
        obs_t e;
    } vec_t;

    logic clk;
    logic nrst;
    logic start1, valid1, start2, valid2;
    int   checks, errors;

    // instance 1: LOG2N=6, BF_LAT=2
    logic       busy1, inr1, we0_1, we1_1, re0_1, re1_1, sw0_1, sw1_1, bs1, ov1, fd1;
    logic [3:0] stg1;
    logic [4:0] wa0_1, wa1_1, ra0_1, ra1_1, tw1;
    // instance 2: LOG2N=4, BF_LAT=3
    logic       busy2, inr2, we0_2, we1_2, re0_2, re1_2, sw0_2, sw1_2, bs2, ov2, fd2;
    logic [3:0] stg2;
    logic [2:0] wa0_2, wa1_2, ra0_2, ra1_2, tw2;

    fft_ctrl_param #(.LOG2N(6), .BF_LAT(2)) u_dut1 (
        .clk(clk), .nrst(nrst), .start(start1), .valid(valid1),
        .busy(busy1), .in_ready(inr1), .stage(stg1),
        .we_b0(we0_1), .we_b1(we1_1), .re_b0(re0_1), .re_b1(re1_1),
        .waddr_b0(wa0_1), .waddr_b1(wa1_1), .raddr_b0(ra0_1), .raddr_b1(ra1_1),
        .swap0_en(sw0_1), .swap1_en(sw1_1), .tw_idx(tw1),
        .bank_select(bs1), .out_valid(ov1), .frame_done(fd1)
    );

    fft_ctrl_param #(.LOG2N(4), .BF_LAT(3)) u_dut2 (
        .clk(clk), .nrst(nrst), .start(start2), .valid(valid2),
        .busy(busy2), .in_ready(inr2), .stage(stg2),
        .we_b0(we0_2), .we_b1(we1_2), .re_b0(re0_2), .re_b1(re1_2),
        .waddr_b0(wa0_2), .waddr_b1(wa1_2), .raddr_b0(ra0_2), .raddr_b1(ra1_2),
        .swap0_en(sw0_2), .swap1_en(sw1_2), .tw_idx(tw2),
        .bank_select(bs2), .out_valid(ov2), .frame_done(fd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(int stage, int busy, int inr, int we0, int we1, int re0, int re1,
                                int wa0, int wa1, int ra0, int ra1, int sw0, int sw1, int tw,
                                int bs, int ov, int fd);
        obs_t o;
        o.stage = 4'(stage); o.busy = 1'(busy); o.in_ready = 1'(inr);
        o.we0 = 1'(we0); o.we1 = 1'(we1); o.re0 = 1'(re0); o.re1 = 1'(re1);
        o.wa0 = 10'(wa0); o.wa1 = 10'(wa1); o.ra0 = 10'(ra0); o.ra1 = 10'(ra1);
        o.sw0 = 1'(sw0); o.sw1 = 1'(sw1); o.tw = 10'(tw);
        o.bs = 1'(bs); o.ov = 1'(ov); o.fd = 1'(fd);
        return o;
    endfunction

    function automatic obs_t get1();
        return mk(int'(stg1), int'(busy1), int'(inr1), int'(we0_1), int'(we1_1), int'(re0_1),
                  int'(re1_1), int'(wa0_1), int'(wa1_1), int'(ra0_1), int'(ra1_1), int'(sw0_1),
                  int'(sw1_1), int'(tw1), int'(bs1), int'(ov1), int'(fd1));
    endfunction

    function automatic obs_t get2();
        return mk(int'(stg2), int'(busy2), int'(inr2), int'(we0_2), int'(we1_2), int'(re0_2),
                  int'(re1_2), int'(wa0_2), int'(wa1_2), int'(ra0_2), int'(ra1_2), int'(sw0_2),
                  int'(sw1_2), int'(tw2), int'(bs2), int'(ov2), int'(fd2));
    endfunction

    function automatic int par(int x);
        int r = 0;
        for (int i = 0; i < 16; i++) r ^= (x >> i) & 1;
        return r;
    endfunction

    function automatic int unl_idx(int k, int L);
        int r = k;
`ifdef FFTC_NATURAL_ORDER_EN
        r = 0;
        for (int i = 0; i < L; i++) if (((k >> i) & 1) == 1) r += 1 << (L - 1 - i);
`endif
        return r;
    endfunction

    task automatic pair(input int L, input int s, input int m,
                        output int ra0, output int ra1, output int sw, output int tw);
        int h, j, k;
        h = 1 << (L - s);
        j = (m / h) * 2 * h + (m % h);
        k = j + h;
        sw = par(j);
        ra0 = (sw == 0) ? j / 2 : k / 2;
        ra1 = (sw == 0) ? k / 2 : j / 2;
        tw = (m % h) * (1 << (s - 1));
    endtask

    // Expected outputs on the t-th valid cycle after start acceptance (t=0).
    task automatic model(input int L, input int B, input int t, output obs_t o);
        int n, hf, sc, st, un, u, s, c, a0, a1, sw, tw, k, idx;
        n = 1 << L; hf = n / 2; sc = hf + B; st = n + 1; un = st + L * sc;
        o = '0;
        if (t >= 1 && t <= un + n) o.busy = 1'b1;
        if (t >= 1 && t <= n) begin
            k = t - 1;
            o.in_ready = 1'b1;
            o.we0 = 1'(1 - par(k)); o.we1 = 1'(par(k));
            o.wa0 = 10'(k / 2); o.wa1 = 10'(k / 2); o.bs = 1'(par(k));
        end else if (t >= st && t < un) begin
            u = t - st; s = u / sc + 1; c = u % sc;
            o.stage = 4'(s);
            if (c < hf) begin
                pair(L, s, c, a0, a1, sw, tw);
                o.re0 = 1'b1; o.re1 = 1'b1; o.ra0 = 10'(a0); o.ra1 = 10'(a1);
            end
            if (c >= 1 && c <= hf) begin
                pair(L, s, c - 1, a0, a1, sw, tw);
                o.sw0 = 1'(sw); o.tw = 10'(tw);
            end
            if (c >= B && c - B < hf) begin
                pair(L, s, c - B, a0, a1, sw, tw);
                o.we0 = 1'b1; o.we1 = 1'b1; o.wa0 = 10'(a0); o.wa1 = 10'(a1); o.sw1 = 1'(sw);
            end
        end else if (t >= un && t <= un + n) begin
            k = t - un;
            o.stage = 4'(L + 1);
            if (k < n) begin
                idx = unl_idx(k, L);
                o.re0 = 1'(1 - par(idx)); o.re1 = 1'(par(idx));
                o.ra0 = 10'(idx / 2); o.ra1 = 10'(idx / 2);
            end
            if (k >= 1) begin
                o.ov = 1'b1; o.bs = 1'(par(unl_idx(k - 1, L))); o.fd = 1'(k == n);
            end
        end
    endtask

    task automatic check(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    localparam int NV = 19;
    vec_t tbl [NV];

    initial begin
        int   r270, r271, r272, t, cyc;
        bit   v;
        obs_t e, g;

        checks = 0; errors = 0;
`ifdef FFTC_NATURAL_ORDER_EN
        r270 = 16; r271 = 8; r272 = 24;
`else
        r270 = 0; r271 = 1; r272 = 1;
`endif
        //                stg bsy rdy we0 we1 re0 re1 wa0 wa1 ra0 ra1 sw0 sw1 tw bs ov fd
        tbl[0]  = '{0,   mk(0, 0, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0,  0, 0, 0)};
        tbl[1]  = '{1,   mk(0, 1, 1, 1, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0,  0, 0, 0)};
        tbl[2]  = '{4,   mk(0, 1, 1, 1, 0, 0, 0, 1,  1,  0,  0,  0, 0, 0,  0, 0, 0)};
        tbl[3]  = '{8,   mk(0, 1, 1, 0, 1, 0, 0, 3,  3,  0,  0,  0, 0, 0,  1, 0, 0)};
        tbl[4]  = '{65,  mk(1, 1, 0, 0, 0, 1, 1, 0,  0,  0,  16, 0, 0, 0,  0, 0, 0)};
        tbl[5]  = '{66,  mk(1, 1, 0, 0, 0, 1, 1, 0,  0,  16, 0,  0, 0, 0,  0, 0, 0)};
        tbl[6]  = '{67,  mk(1, 1, 0, 1, 1, 1, 1, 0,  16, 17, 1,  1, 0, 1,  0, 0, 0)};
        tbl[7]  = '{68,  mk(1, 1, 0, 1, 1, 1, 1, 16, 0,  1,  17, 1, 1, 2,  0, 0, 0)};
        tbl[8]  = '{97,  mk(1, 1, 0, 1, 1, 0, 0, 15, 31, 0,  0,  1, 0, 31, 0, 0, 0)};
        tbl[9]  = '{98,  mk(1, 1, 0, 1, 1, 0, 0, 31, 15, 0,  0,  0, 1, 0,  0, 0, 0)};
        tbl[10] = '{99,  mk(2, 1, 0, 0, 0, 1, 1, 0,  0,  0,  8,  0, 0, 0,  0, 0, 0)};
        tbl[11] = '{238, mk(6, 1, 0, 1, 1, 1, 1, 1,  1,  3,  3,  1, 1, 0,  0, 0, 0)};
        tbl[12] = '{268, mk(6, 1, 0, 1, 1, 0, 0, 31, 31, 0,  0,  0, 1, 0,  0, 0, 0)};
        tbl[13] = '{269, mk(7, 1, 0, 0, 0, 1, 0, 0,  0,  0,  0,  0, 0, 0,  0, 0, 0)};
        tbl[14] = '{270, mk(7, 1, 0, 0, 0, 0, 1, 0,  0, r270, r270, 0, 0, 0, 0, 1, 0)};
        tbl[15] = '{271, mk(7, 1, 0, 0, 0, 0, 1, 0,  0, r271, r271, 0, 0, 0, 1, 1, 0)};
        tbl[16] = '{272, mk(7, 1, 0, 0, 0, 1, 0, 0,  0, r272, r272, 0, 0, 0, 1, 1, 0)};
        tbl[17] = '{332, mk(7, 1, 0, 0, 0, 1, 0, 0,  0,  31, 31, 0, 0, 0,  1, 1, 0)};
        tbl[18] = '{333, mk(7, 1, 0, 0, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0,  0, 1, 1)};

        nrst = 1'b0; start1 = 1'b0; valid1 = 1'b1; start2 = 1'b0; valid2 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", get1(), '0);
        nrst = 1'b1;

        // Frame on instance 1, valid held high, table-driven comparisons.
        for (int ti = 0; ti <= 334; ti++) begin
            @(negedge clk);
            start1 = (ti == 0); valid1 = 1'b1;
            #2;
            g = get1();
            for (int i = 0; i < NV; i++)
                if (tbl[i].t == ti) check($sformatf("frame1_t%0d", ti), g, tbl[i].e);
            if (ti == 334) check("idle_after_frame", g, '0);
        end

        // Abort mid stage 3 with an asynchronous reset, then restart.
        for (int ti = 0; ti <= 143; ti++) begin
            @(negedge clk);
            start1 = (ti == 0); valid1 = 1'b1;
        end
        #2;
        check("stage3_before_reset_stage", mk(int'(stg1), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0),
              mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        nrst = 1'b0;
        #1;
        check("async_reset_outputs", get1(), '0);
        @(negedge clk);
        check("reset_held_outputs", get1(), '0);
        nrst = 1'b1; start1 = 1'b1;
        #2;
        check("restart_idle", get1(), '0);
        @(negedge clk);
        start1 = 1'b0;
        #2;
        check("restart_load_k0", get1(), mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        valid1 = 1'b0;

        // Randomly stalled frame on instance 2 against the bench model.
        t = 0; cyc = 0;
        while (t <= 78 && cyc < 3000) begin
            @(negedge clk);
            v = 1'($urandom_range(0, 1));
            valid2 = v; start2 = (t == 0);
            #2;
            g = get2();
            model(4, 3, t, e);
            if (v) begin
                check($sformatf("stall_frame_t%0d", t), g, e);
                t++;
            end else begin
                check($sformatf("stalled_t%0d", t), g,
                      mk(int'(e.stage), int'(e.busy), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
            end
            cyc++;
        end
        if (t <= 78) begin
            errors++;
            $display("FAIL stall_frame_timeout: reached t=%0d required t=79", t);
        end
        valid2 = 1'b0; start2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
